// File: rtl/idp_pkg.sv
// Shared constants and types for the IDP window tracker.
package idp_pkg;

    localparam int unsigned IDP_ADDR_W   = 20;
    localparam int unsigned IDP_NUM_TAPS = 8;
    localparam int unsigned IDP_DEPTH    = 16;
    localparam int unsigned IDP_STEP_W   = 4;
    localparam int unsigned IDP_PTR_W    = $clog2(IDP_DEPTH);
    localparam int unsigned IDP_CNT_W    = $clog2(IDP_DEPTH) + 1;

    typedef logic [IDP_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/idp_ring_buffer.sv
// Address ring: storage, read/write pointers, occupancy count and sticky overflow flag.
module idp_ring_buffer
    import idp_pkg::*;
#(
    parameter int unsigned ADDR_W = IDP_ADDR_W,
    parameter int unsigned DEPTH  = IDP_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr_vld,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_adv,
    input  logic [CNT_W-1:0]  i_adv_step,
    output logic              o_wr_rdy,
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_count_nxt_c,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_ovf_err,
    output logic [PTR_W-1:0]  o_rd_ptr,
    output logic [ADDR_W-1:0] o_mem [DEPTH]
);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_rdy;
    logic              r_full;
    logic              r_empty;
    logic              r_ovf_err;

    logic              w_push;
    logic              w_ovf;
    logic [CNT_W-1:0]  w_count_nxt;

    // wr_rdy is the registered view of space, so a same-cycle advance never bypasses it
    assign w_push = i_wr_vld & r_wr_rdy & ~i_flush;
    assign w_ovf  = i_wr_vld & ~r_wr_rdy & ~i_flush;

    always_comb begin
        w_count_nxt = r_count + CNT_W'(w_push);
        if (i_adv) begin
            w_count_nxt = w_count_nxt - i_adv_step;
        end
        if (i_flush) begin
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wr_rdy  <= 1'b1;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (i_adv) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(i_adv_step);
                end
            end
            r_count  <= w_count_nxt;
            r_wr_rdy <= (w_count_nxt < CNT_W'(DEPTH));
            r_full   <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty  <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset: unused slots are masked off at the taps
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_wr_addr;
        end
    end

    assign o_wr_rdy      = r_wr_rdy;
    assign o_count       = r_count;
    assign o_count_nxt_c = w_count_nxt;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_ovf_err     = r_ovf_err;
    assign o_rd_ptr      = r_rd_ptr;
    assign o_mem         = r_mem;

endmodule

// File: rtl/idp_window_tracker.sv
// Sliding window over landed pixel-memory line addresses, with strided advance,
// backpressure, flush and end-of-feature-map drain.
module idp_window_tracker
    import idp_pkg::*;
#(
    parameter int unsigned ADDR_W   = IDP_ADDR_W,
    parameter int unsigned NUM_TAPS = IDP_NUM_TAPS,
    parameter int unsigned DEPTH    = IDP_DEPTH,
    parameter int unsigned STEP_W   = IDP_STEP_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       drain,
    input  logic                       wr_vld,
    output logic                       wr_rdy,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       rd_req,
    input  logic [STEP_W-1:0]          rd_step,
    output logic                       rd_ack,
    output logic                       win_vld,
    output logic [NUM_TAPS-1:0]        win_mask,
    output logic [NUM_TAPS*ADDR_W-1:0] win_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned CMP_W = (STEP_W > CNT_W) ? STEP_W : CNT_W;

    logic [ADDR_W-1:0]   w_mem [DEPTH];
    logic [PTR_W-1:0]    w_rd_ptr;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CMP_W-1:0]    w_step_cmp;
    logic [CNT_W-1:0]    w_eff_step;
    logic [NUM_TAPS-1:0] w_mask_nxt;
    logic                w_rd_ack;

    logic                r_win_vld;
    logic [NUM_TAPS-1:0] r_win_mask;

    idp_ring_buffer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ring (
        .clk           (clk),
        .rst           (rst),
        .i_flush       (flush),
        .i_wr_vld      (wr_vld),
        .i_wr_addr     (wr_addr),
        .i_adv         (w_rd_ack),
        .i_adv_step    (w_eff_step),
        .o_wr_rdy      (wr_rdy),
        .o_count       (w_count),
        .o_count_nxt_c (w_count_nxt),
        .o_full        (full),
        .o_empty       (empty),
        .o_ovf_err     (ovf_err),
        .o_rd_ptr      (w_rd_ptr),
        .o_mem         (w_mem)
    );

    // Clamp to the window width and to what is live, so a drain tail retires cleanly
    always_comb begin
        w_step_cmp = CMP_W'(rd_step);
        if (w_step_cmp > CMP_W'(NUM_TAPS)) begin
            w_step_cmp = CMP_W'(NUM_TAPS);
        end
        if (w_step_cmp > CMP_W'(w_count)) begin
            w_step_cmp = CMP_W'(w_count);
        end
    end

    assign w_eff_step = CNT_W'(w_step_cmp);
    assign w_rd_ack   = rd_req & r_win_vld & (rd_step != '0) & ~flush & ~rst;

    always_comb begin
        w_mask_nxt = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_mask_nxt[k] = (CNT_W'(k) < w_count_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_vld  <= 1'b0;
            r_win_mask <= '0;
        end else begin
            r_win_vld  <= (w_count_nxt >= CNT_W'(NUM_TAPS)) | (drain & (w_count_nxt != '0));
            r_win_mask <= w_mask_nxt;
        end
    end

    // Tap k reads slot rd_ptr+k; dead taps read zero
    always_comb begin
        win_addr = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (r_win_mask[k]) begin
                win_addr[k*ADDR_W +: ADDR_W] = w_mem[w_rd_ptr + PTR_W'(k)];
            end
        end
    end

    assign rd_ack   = w_rd_ack;
    assign win_vld  = r_win_vld;
    assign win_mask = r_win_mask;
    assign count    = w_count;

endmodule

// File: tb/tb_idp_window_tracker.sv
// Directed bench for idp_window_tracker with hand-computed expectations.
module tb_idp_window_tracker;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         drain = 1'b0;
    logic         wr_vld = 1'b0;
    logic         wr_rdy;
    logic [19:0]  wr_addr = '0;
    logic         rd_req = 1'b0;
    logic [3:0]   rd_step = '0;
    logic         rd_ack;
    logic         win_vld;
    logic [7:0]   win_mask;
    logic [159:0] win_addr;
    logic [4:0]   count;
    logic         full;
    logic         empty;
    logic         ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    idp_window_tracker dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .drain    (drain),
        .wr_vld   (wr_vld),
        .wr_rdy   (wr_rdy),
        .wr_addr  (wr_addr),
        .rd_req   (rd_req),
        .rd_step  (rd_step),
        .rd_ack   (rd_ack),
        .win_vld  (win_vld),
        .win_mask (win_mask),
        .win_addr (win_addr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] tap(input int k);
        return win_addr[k*20 +: 20];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] a);
        wr_vld  = 1'b1;
        wr_addr = a;
        tick();
        wr_vld  = 1'b0;
    endtask

    task automatic advance(input logic [3:0] s, input logic exp_ack, input string tag);
        rd_req  = 1'b1;
        rd_step = s;
        #1;
        chk(tag, 32'(rd_ack), 32'(exp_ack));
        tick();
        rd_req  = 1'b0;
        rd_step = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // T1: reset and fill
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count",   32'(count),    32'd0);
        chk("rst_empty",   32'(empty),    32'd1);
        chk("rst_full",    32'(full),     32'd0);
        chk("rst_wr_rdy",  32'(wr_rdy),   32'd1);
        chk("rst_win_vld", 32'(win_vld),  32'd0);
        chk("rst_mask",    32'(win_mask), 32'd0);
        chk("rst_ovf",     32'(ovf_err),  32'd0);
        chk("rst_tap0",    32'(tap(0)),   32'd0);

        push(20'h100);
        chk("t1_lat_tap0",  32'(tap(0)),   32'h100);
        chk("t1_lat_count", 32'(count),    32'd1);
        for (int i = 1; i < 7; i++) push(20'(32'h100 + i));
        chk("t1_vld_7", 32'(win_vld), 32'd0);
        push(20'h107);
        chk("t1_vld_8", 32'(win_vld),  32'd1);
        chk("t1_tap0",  32'(tap(0)),   32'h100);
        chk("t1_tap7",  32'(tap(7)),   32'h107);
        chk("t1_count", 32'(count),    32'd8);
        chk("t1_mask",  32'(win_mask), 32'hFF);

        // T2: stride advance and zero step
        for (int i = 8; i < 12; i++) push(20'(32'h100 + i));
        chk("t2_count12", 32'(count), 32'd12);
        advance(4'd4, 1'b1, "t2_ack4");
        chk("t2_tap0",  32'(tap(0)), 32'h104);
        chk("t2_count", 32'(count),  32'd8);
        advance(4'd0, 1'b0, "t2_ack0");
        chk("t2_z_count", 32'(count),  32'd8);
        chk("t2_z_tap0",  32'(tap(0)), 32'h104);

        // T3: full and overflow
        do_flush();
        chk("t3_flush_count", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++) push(20'(32'h200 + i));
        chk("t3_full",   32'(full),   32'd1);
        chk("t3_wr_rdy", 32'(wr_rdy), 32'd0);
        chk("t3_ovf0",   32'(ovf_err), 32'd0);
        push(20'h2FF);
        chk("t3_count_drop", 32'(count),   32'd16);
        chk("t3_ovf1",       32'(ovf_err), 32'd1);
        advance(4'd8, 1'b1, "t3_ack");
        chk("t3_adv_count", 32'(count),   32'd8);
        chk("t3_adv_ovf",   32'(ovf_err), 32'd1);
        chk("t3_adv_full",  32'(full),    32'd0);
        chk("t3_adv_rdy",   32'(wr_rdy),  32'd1);
        chk("t3_adv_tap0",  32'(tap(0)),  32'h208);

        // T4: push and advance in the same cycle
        push(20'h300);
        push(20'h301);
        chk("t4_count10", 32'(count), 32'd10);
        wr_vld  = 1'b1;
        wr_addr = 20'h3AA;
        advance(4'd3, 1'b1, "t4_ack");
        wr_vld  = 1'b0;
        chk("t4_count", 32'(count),  32'd8);
        chk("t4_tap0",  32'(tap(0)), 32'h20B);
        chk("t4_tap7",  32'(tap(7)), 32'h3AA);

        // T5: drain with a partial window
        do_flush();
        chk("t5_ovf_kept", 32'(ovf_err), 32'd1);
        for (int i = 0; i < 3; i++) push(20'(32'h500 + i));
        chk("t5_vld_nodrain", 32'(win_vld),  32'd0);
        chk("t5_mask",        32'(win_mask), 32'h07);
        advance(4'd1, 1'b0, "t5_ack_nodrain");
        drain = 1'b1;
        tick();
        chk("t5_vld_drain", 32'(win_vld), 32'd1);
        chk("t5_tap0",      32'(tap(0)),  32'h500);
        chk("t5_tap2",      32'(tap(2)),  32'h502);
        chk("t5_tap3",      32'(tap(3)),  32'd0);
        chk("t5_tap7",      32'(tap(7)),  32'd0);
        drain = 1'b0;
        tick();
        chk("t5_vld_leave", 32'(win_vld), 32'd0);
        drain = 1'b1;
        tick();
        advance(4'd8, 1'b1, "t5_ack8");
        chk("t5_empty", 32'(empty),   32'd1);
        chk("t5_count", 32'(count),   32'd0);
        chk("t5_vld_e", 32'(win_vld), 32'd0);
        drain = 1'b0;

        // T6: pointer wrap then flush with a concurrent write
        do_flush();
        for (int i = 0; i < 8; i++) push(20'(32'h600 + i));
        for (int i = 8; i < 40; i++) begin
            wr_vld  = 1'b1;
            wr_addr = 20'(32'h600 + i);
            advance(4'd1, 1'b1, "t6_ack");
        end
        wr_vld = 1'b0;
        chk("t6_count", 32'(count),  32'd8);
        chk("t6_tap0",  32'(tap(0)), 32'h620);
        chk("t6_tap7",  32'(tap(7)), 32'h627);
        flush   = 1'b1;
        wr_vld  = 1'b1;
        wr_addr = 20'hBAD;
        rd_req  = 1'b1;
        rd_step = 4'd1;
        #1;
        chk("t6_flush_ack", 32'(rd_ack), 32'd0);
        tick();
        flush   = 1'b0;
        wr_vld  = 1'b0;
        rd_req  = 1'b0;
        rd_step = '0;
        chk("t6_fl_count", 32'(count),    32'd0);
        chk("t6_fl_empty", 32'(empty),    32'd1);
        chk("t6_fl_vld",   32'(win_vld),  32'd0);
        chk("t6_fl_mask",  32'(win_mask), 32'd0);
        chk("t6_fl_tap0",  32'(tap(0)),   32'd0);
        push(20'h700);
        chk("t6_post_count", 32'(count),  32'd1);
        chk("t6_post_tap0",  32'(tap(0)), 32'h700);

        // Only reset clears the sticky overflow
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_ovf",   32'(ovf_err), 32'd0);
        chk("rst2_count", 32'(count),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
